// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
//
// Shared definitions for the FIFO read-side word packer:
//   FIFO_DATA_WIDTH : default FIFO word width
//   DEFAULT_PACK    : default number of words per output beat
//   MAX_PACK        : largest supported PACK value
//   pack_state_t    : packer control state {FILL, HOLD, FLUSH}
//   lane_cnt_t      : lane counter able to hold 0..MAX_PACK
//   lane_filled()   : true when a lane index lies below the fill count
// ----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 32;
    localparam int DEFAULT_PACK    = 2;
    localparam int MAX_PACK        = 8;

    typedef enum logic [1:0] {
        FILL  = 2'd0,   // reading and accumulating words
        HOLD  = 2'd1,   // all lanes filled, output register still busy
        FLUSH = 2'd2    // flush requested, reads blocked until resolved
    } pack_state_t;

    // Sized for the largest legal PACK so any instance can share the type.
    typedef logic [$clog2(MAX_PACK + 1) - 1:0] lane_cnt_t;

    // A lane holds live data when its index is below the fill count.
    function automatic logic lane_filled(input int lane, input lane_cnt_t cnt);
        return lane_cnt_t'(lane) < cnt;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// ----------------------------------------------------------------------------
// pack_out_reg
//
// Output beat register with valid/ready hold behaviour. Once a beat is
// loaded it stays stable until accepted; a new beat may be loaded in the
// same cycle the current one is accepted, so there is no bubble.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-low reset
//   load       : capture load_data/load_mask into the register
//   load_data  : packed beat to present
//   load_mask  : lane-valid mask for the beat
//   pkt_ready  : downstream accepts the current beat
//   pkt_data   : registered beat data
//   pkt_mask   : registered lane mask
//   pkt_valid  : beat available
//   free       : register can accept a load this cycle
// ----------------------------------------------------------------------------
module pack_out_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int PACK       = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic [DATA_WIDTH*PACK-1:0] load_data,
    input  logic [PACK-1:0]            load_mask,
    input  logic                       pkt_ready,
    output logic [DATA_WIDTH*PACK-1:0] pkt_data,
    output logic [PACK-1:0]            pkt_mask,
    output logic                       pkt_valid,
    output logic                       free
);

    // Free when empty, or when the current beat leaves on this edge.
    assign free = !pkt_valid || pkt_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_data  <= '0;
            pkt_mask  <= '0;
            pkt_valid <= 1'b0;
        end else if (load) begin
            pkt_data  <= load_data;
            pkt_mask  <= load_mask;
            pkt_valid <= 1'b1;
        end else if (pkt_ready) begin
            // Data/mask are left as-is; only valid drops after acceptance.
            pkt_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_word_packer.sv
// ----------------------------------------------------------------------------
// fifo_word_packer
//
// Read-side drain stage for the synchronous FIFO. Pops words whenever there
// is room, packs PACK consecutive words into one wide beat (lane 0 at the
// LSBs) and presents it on a valid/ready port. A flush pulse forces out any
// partially filled beat with a lane mask.
//
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous active-low reset (shared with the FIFO)
//   Read_enable : pop request to the FIFO (combinational from empty + state)
//   empty       : FIFO empty flag
//   fifo_data   : FIFO read data, valid the cycle after a pop
//   flush       : single-cycle request to emit a partial beat
//   pkt_data    : packed output beat
//   pkt_mask    : bit i set = lane i holds a valid word
//   pkt_valid   : beat available
//   pkt_ready   : downstream accepts the beat
// ----------------------------------------------------------------------------
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int PACK       = DEFAULT_PACK
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       Read_enable,
    input  logic                       empty,
    input  logic [DATA_WIDTH-1:0]      fifo_data,
    input  logic                       flush,
    output logic [DATA_WIDTH*PACK-1:0] pkt_data,
    output logic [PACK-1:0]            pkt_mask,
    output logic                       pkt_valid,
    input  logic                       pkt_ready
);

    localparam lane_cnt_t PACK_CNT = lane_cnt_t'(PACK);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    pack_state_t state_reg;
    lane_cnt_t   cnt_reg;       // lanes already holding a word
    lane_cnt_t   cnt_next;
    lane_cnt_t   cnt_cap;       // lane count including this cycle's capture
    logic        pend_reg;      // a popped word arrives on fifo_data now
    logic        active_reg;    // first cycle after reset release is idle

    logic        flush_pend;
    logic        lanes_full;
    logic        out_free;
    logic        load_full;
    logic        load_part;
    logic        load;
    logic        flush_clear;

    logic [DATA_WIDTH*PACK-1:0] load_data;
    logic [PACK-1:0]            load_mask;

    // The flush-pending flag is exactly "being in FLUSH": a flush moves the
    // FSM there and clearing the flag moves it back to FILL.
    assign flush_pend = (state_reg == FLUSH);

    assign cnt_cap    = cnt_reg + lane_cnt_t'(pend_reg);
    assign lanes_full = (cnt_cap == PACK_CNT);

    // A full beat loads on the same edge its last word is captured.
    assign load_full  = lanes_full && out_free;

    // Partial beat only once the in-flight word has landed.
    assign load_part  = flush_pend && !pend_reg &&
                        (cnt_reg != '0) && (cnt_reg < PACK_CNT) && out_free;

    assign load       = load_full || load_part;

    // Empty or complete accumulators need no partial beat; a complete one
    // drains through the normal full-beat path.
    assign flush_clear = flush_pend && !pend_reg &&
                         ((cnt_reg == '0) || (cnt_reg == PACK_CNT) || load_part);

    assign cnt_next = load ? '0 : cnt_cap;

    // Room exists while the lanes plus the in-flight word leave a gap. The
    // second term lets a read overlap the capture that completes a beat,
    // which is safe only when that beat is guaranteed to load (register
    // idle); pkt_ready is deliberately not used here.
    assign Read_enable = active_reg && !empty && !flush_pend &&
                         ((cnt_cap < PACK_CNT) ||
                          (lanes_full && pend_reg && !pkt_valid));

    // ------------------------------------------------------------------
    // Accumulator lanes and beat assembly
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            localparam lane_cnt_t LANE = lane_cnt_t'(gi);

            logic [DATA_WIDTH-1:0] lane_q;
            logic                  cap_here;
            logic                  filled;

            assign cap_here = pend_reg && (cnt_reg == LANE);
            assign filled   = lane_filled(gi, cnt_reg);

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lane_q <= '0;
                end else if (cap_here) begin
                    lane_q <= fifo_data;
                end
            end

            // The word being captured bypasses into the beat so a full beat
            // can load on its capturing edge; unfilled lanes read as zero.
            assign load_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                filled   ? lane_q    :
                cap_here ? fifo_data : '0;

            assign load_mask[gi] = load_full || filled;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= FILL;
            cnt_reg    <= '0;
            pend_reg   <= 1'b0;
            active_reg <= 1'b0;
        end else begin
            active_reg <= 1'b1;
            pend_reg   <= Read_enable;
            cnt_reg    <= cnt_next;

            case (state_reg)
                FILL: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                    end else if (lanes_full && !out_free) begin
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state_reg <= FLUSH;
                    end else if (load_full) begin
                        state_reg <= FILL;
                    end
                end
                FLUSH: begin
                    // Further flush pulses are absorbed while here.
                    if (flush_clear) begin
                        state_reg <= FILL;
                    end
                end
                default: begin
                    state_reg <= FILL;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    pack_out_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .PACK       (PACK)
    ) u_out (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_mask (load_mask),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .pkt_mask  (pkt_mask),
        .pkt_valid (pkt_valid),
        .free      (out_free)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_word_packer
//
// Bench for fifo_word_packer (DATA_WIDTH=32, PACK=2). A behavioural FIFO
// feeds the packer; every word it hands out is grouped into expected beats
// (PACK words per beat, or fewer when a flush closes a group). Accepted
// beats are compared in order against that list; directed scenarios add
// literal expectations on top.
// ----------------------------------------------------------------------------
module tb_fifo_word_packer;

    localparam int DW = 32;
    localparam int P  = 2;

    typedef struct packed {
        logic [DW*P-1:0] data;
        logic [P-1:0]    mask;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            Read_enable;
    logic            empty;
    logic [DW-1:0]   fifo_data;
    logic            flush = 1'b0;
    logic [DW*P-1:0] pkt_data;
    logic [P-1:0]    pkt_mask;
    logic            pkt_valid;
    logic            pkt_ready = 1'b0;

    fifo_word_packer #(
        .DATA_WIDTH (DW),
        .PACK       (P)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Read_enable (Read_enable),
        .empty       (empty),
        .fifo_data   (fifo_data),
        .flush       (flush),
        .pkt_data    (pkt_data),
        .pkt_mask    (pkt_mask),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q[$];      // FIFO contents
    logic [DW-1:0] cur[$];    // popped words not yet closed into a beat
    beat_t         exp_q[$];  // beats the packer must deliver, in order
    beat_t         got_q[$];  // beats accepted in the current scenario

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;
    logic tgl_mode = 1'b0;
    logic tgl      = 1'b0;

    task automatic check(input string name, input logic [DW*P-1:0] act,
                         input logic [DW*P-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Close the current group of words into a beat: word i in lane i,
    // mask bit i set for each word present.
    function automatic beat_t close_group();
        beat_t b;
        b.data = '0;
        b.mask = '0;
        foreach (cur[i]) begin
            b.data[i*DW +: DW] = cur[i];
            b.mask[i]          = 1'b1;
        end
        return b;
    endfunction

    // Behavioural FIFO + beat model. A flush closes whatever has been
    // popped up to and including its own edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            empty     <= (q.size() == 0);
            fifo_data <= '0;
            tgl       <= 1'b0;
            cur.delete();
            exp_q.delete();
        end else begin
            if (Read_enable && !empty) begin
                if (q.size() > 0) begin
                    fifo_data <= q[0];
                    cur.push_back(q[0]);
                    void'(q.pop_front());
                end else begin
                    fifo_data <= '0;
                    cur.push_back('0);
                end
                n_pops <= n_pops + 1;
                if (cur.size() == P) begin
                    exp_q.push_back(close_group());
                    cur.delete();
                end
            end
            if (flush && cur.size() > 0) begin
                exp_q.push_back(close_group());
                cur.delete();
            end
            tgl   <= ~tgl;
            empty <= (q.size() == 0) || (tgl_mode && tgl);
        end
    end

    // Per-cycle checker: no pop while empty, beats held stable until
    // accepted, and every accepted beat matches the model in order.
    logic            hold_prev = 1'b0;
    logic [DW*P-1:0] prev_data = '0;
    logic [P-1:0]    prev_mask = '0;

    always @(negedge clk) begin
        if (reset) begin
            check("no_pop_when_empty", {63'd0, Read_enable & empty}, '0);
            if (hold_prev) begin
                check("valid_held", {63'd0, pkt_valid}, 1);
                check("data_held", pkt_data, prev_data);
                check("mask_held", {62'd0, pkt_mask}, {62'd0, prev_mask});
            end
            if (pkt_valid && pkt_ready) begin
                check("beat_expected", {63'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    check("beat_data", pkt_data, exp_q[0].data);
                    check("beat_mask", {62'd0, pkt_mask}, {62'd0, exp_q[0].mask});
                    void'(exp_q.pop_front());
                end
                got_q.push_back({pkt_data, pkt_mask});
                $display("beat accepted data=%h mask=%b t=%0t", pkt_data, pkt_mask, $time);
            end
            hold_prev <= pkt_valid && !pkt_ready;
            prev_data <= pkt_data;
            prev_mask <= pkt_mask;
        end else begin
            hold_prev <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats(input int k, input int budget, input string name);
        int c = 0;
        while (got_q.size() < k && c < budget) begin
            tick(1);
            c++;
        end
        check(name, {63'd0, got_q.size() >= k}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    int pops0;

    initial begin
        // ---------------- reset with words already queued ----------------
        q.push_back(32'h11); q.push_back(32'h22);
        q.push_back(32'h33); q.push_back(32'h44);
        tick(3);
        check("rst_empty_low", {63'd0, empty}, 0);
        check("rst_read_enable", {63'd0, Read_enable}, 0);
        check("rst_valid", {63'd0, pkt_valid}, 0);
        check("rst_data", pkt_data, 0);
        check("rst_mask", {62'd0, pkt_mask}, 0);

        // ---------------- release and stream ----------------
        pkt_ready = 1'b1;
        reset     = 1'b1;
        check("re_release_cycle", {63'd0, Read_enable}, 0);
        tick(1);
        for (int i = 0; i < 4; i++) begin
            check("re_stream", {63'd0, Read_enable}, 1);
            if (i == 3) check("latency_valid", {63'd0, pkt_valid}, 1);
            if (i == 2) check("latency_not_yet", {63'd0, pkt_valid}, 0);
            tick(1);
        end
        check("re_stream_end", {63'd0, Read_enable}, 0);
        wait_beats(2, 20, "stream_beats");
        if (got_q.size() >= 2) begin
            check("stream_beat0", got_q[0].data, 64'h00000022_00000011);
            check("stream_mask0", {62'd0, got_q[0].mask}, 2'b11);
            check("stream_beat1", got_q[1].data, 64'h00000044_00000033);
            check("stream_mask1", {62'd0, got_q[1].mask}, 2'b11);
        end

        // ---------------- backpressure ----------------
        got_q.delete();
        pkt_ready = 1'b0;
        pops0 = n_pops;
        for (int i = 1; i <= 6; i++) q.push_back(32'h100 + i);
        tick(10);
        check("bp_pops", (n_pops - pops0), 2 * P);
        check("bp_read_enable", {63'd0, Read_enable}, 0);
        check("bp_valid", {63'd0, pkt_valid}, 1);
        check("bp_data", pkt_data, 64'h00000102_00000101);
        pkt_ready = 1'b1;
        wait_beats(3, 40, "bp_beats");
        if (got_q.size() >= 3) begin
            check("bp_beat2", got_q[2].data, 64'h00000106_00000105);
        end

        // ---------------- flush of a partial beat ----------------
        got_q.delete();
        q.push_back(32'hA5);
        tick(5);
        check("fl_idle_valid", {63'd0, pkt_valid}, 0);
        flush = 1'b1;
        q.push_back(32'hB6);
        pops0 = n_pops;
        tick(1);
        flush = 1'b0;
        check("fl_no_pop_pend", {63'd0, Read_enable}, 0);
        tick(1);
        check("fl_pops_blocked", (n_pops - pops0), 0);
        wait_beats(1, 20, "fl_beat");
        if (got_q.size() >= 1) begin
            check("fl_data", got_q[0].data, 64'h00000000_000000A5);
            check("fl_mask", {62'd0, got_q[0].mask}, 2'b01);
        end
        tick(4);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_beats(2, 20, "fl_beat2");
        if (got_q.size() >= 2) begin
            check("fl2_data", got_q[1].data, 64'h00000000_000000B6);
            check("fl2_mask", {62'd0, got_q[1].mask}, 2'b01);
        end

        // ---------------- capture coinciding with flush ----------------
        got_q.delete();
        q.push_back(32'hC1); q.push_back(32'hC2); q.push_back(32'hC3);
        tick(1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        wait_beats(2, 30, "cf_beats");
        if (got_q.size() >= 2) begin
            check("cf_part", got_q[0].data, 64'h00000000_000000C1);
            check("cf_part_mask", {62'd0, got_q[0].mask}, 2'b01);
            check("cf_full", got_q[1].data, 64'h000000C3_000000C2);
        end

        // ---------------- empty toggling every cycle ----------------
        got_q.delete();
        tgl_mode = 1'b1;
        for (int i = 1; i <= 8; i++) q.push_back(32'h500 + i);
        wait_beats(4, 80, "tg_beats");
        tgl_mode = 1'b0;
        if (got_q.size() >= 4) begin
            check("tg_beat0", got_q[0].data, 64'h00000502_00000501);
            check("tg_beat3", got_q[3].data, 64'h00000508_00000507);
        end

        // ---------------- reset mid-beat ----------------
        got_q.delete();
        q.push_back(32'h601);
        tick(4);
        q.delete();
        reset = 1'b0;
        tick(2);
        check("mr_valid_in_reset", {63'd0, pkt_valid}, 0);
        reset = 1'b1;
        q.push_back(32'h701); q.push_back(32'h702);
        wait_beats(1, 20, "mr_beat");
        if (got_q.size() >= 1) begin
            check("mr_data", got_q[0].data, 64'h00000702_00000701);
            check("mr_mask", {62'd0, got_q[0].mask}, 2'b11);
        end

        tick(5);
        check("model_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
# fifo_word_packer

Read-side drain stage sitting directly downstream of the team's synchronous FIFO. It pops words from the FIFO whenever it has room and packs PACK consecutive words into one wide beat. Each beat is presented on a valid/ready output port, with a per-lane mask for partial beats forced out by a flush request. This block is the FIFO's only reader and owns its `Read_enable`.

## Interface
- `DATA_WIDTH`, 32, FIFO word width.
- `PACK`, 2, words per output beat; legal range 2..8.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `Read_enable`  out  1  pop request to the FIFO.
- `empty`  in  1  FIFO empty flag (registered in the FIFO).
- `fifo_data`  in  DATA_WIDTH  FIFO read data.
- `flush`  in  1  single-cycle pulse: emit any partial beat.
- `pkt_data`  out  DATA_WIDTH*PACK  packed beat; lane 0 at the LSBs.
- `pkt_mask`  out  PACK  bit i set = lane i holds a valid word.
- `pkt_valid`  out  1  beat available.
- `pkt_ready`  in  1  downstream accepts the beat.

## Operation
- FIFO read timing is fixed. If `Read_enable` is high in cycle N with `empty` low, `fifo_data` holds that word during cycle N+1. The packer captures the word at the end of N+1. That read is "pending" during N+1.
- Internal state:
  - accumulator of PACK lanes;
  - `cnt` (0..PACK), the number of lanes filled;
  - `pend` (0/1);
  - `flush_pend`;
  - output register (`pkt_data`/`pkt_mask`/`pkt_valid`).
- `Read_enable` = !empty && !flush_pend && (cnt+pend < PACK || (cnt+pend == PACK && pend && !pkt_valid)).
  - It is combinational only from `empty` and registered state.
  - There is no path from `pkt_ready` to `Read_enable`.
- Word capture: a pending word goes into lane `cnt`, and `cnt` increments.
- Beat load: load the output register when the lanes are complete (cnt reaches PACK, including on the capturing edge) and the output register is free.
  - Free means `pkt_valid`=0, or `pkt_valid`&&`pkt_ready` in the same cycle.
  - On load: `pkt_mask` = all ones and `cnt` = 0.
  - If the register is not free, the accumulator holds at `cnt`=PACK and no reads issue.
- Output handshake: `pkt_valid` stays high, with `pkt_data`/`pkt_mask` stable, until sampled together with `pkt_ready`. Dropping `pkt_valid` before acceptance is illegal.
- Flush sequence:
  - A `flush` pulse sets `flush_pend`, and new reads are blocked.
  - Once `pend`=0:
    - if 0<cnt<PACK, load a partial beat: lanes ≥ `cnt` are zero, `pkt_mask` = (1<<cnt)-1, then `cnt` = 0;
    - `flush_pend` clears on that load, or immediately if `cnt` is 0 or PACK (a full beat follows the normal path).
  - A flush arriving while `flush_pend` is already set is absorbed.
- States:
  - FILL: reading and accumulating.
  - HOLD: `cnt`=PACK and the output register is busy.
  - FLUSH: `flush_pend` is set.
  - Transitions:
    - FILL→HOLD when lanes are complete but the register is busy.
    - HOLD→FILL on load.
    - any state→FLUSH on `flush`.
    - FLUSH→FILL on clear.
- Simultaneous events:
  - A capture and a flush in the same cycle: the word is captured first, and it is counted in the partial beat.
  - Acceptance and load in the same cycle: the new beat replaces the old one with no bubble.

## Timing
- Reset (asynchronous assert): `Read_enable`=0, `pkt_valid`=0, `pkt_data`=0, `pkt_mask`=0, and all internal state cleared (`cnt`, `pend`, `flush_pend`, state=FILL).
- Reset mid-operation: any pending FIFO word is discarded. The FIFO itself is reset by the same `reset`.
- Latency: last word of a beat popped in cycle N → `pkt_valid` high in cycle N+2.
- Throughput: with `pkt_ready` held high and the FIFO non-empty, one beat every PACK cycles and `Read_enable` continuously high.
- `empty` is honoured every cycle. A pop is never issued while `empty`=1, including the cycle `empty` rises.

## Structure
- Package `fifo_pkg`:
  - `DATA_WIDTH` default;
  - state enum `pack_state_t` {FILL, HOLD, FLUSH};
  - lane-count type sized `$clog2(PACK+1)`.
- One natural sub-module, `pack_out_reg`: the output register plus its valid/ready hold logic. The read-control, accumulator and FSM live in the top.

## Test plan
- Reset: hold `reset`=0 with `empty`=0 → `Read_enable`=0, `pkt_valid`=0; release reset → `Read_enable` high the next cycle.
- Streaming (PACK=2): FIFO holds 0x11,0x22,0x33,0x44 and `pkt_ready`=1 → beats 0x00000022_00000011 then 0x00000044_00000033, both with mask 2'b11; `Read_enable` high 4 consecutive cycles.
- Backpressure: `pkt_ready`=0 for 10 cycles with 6 words queued → exactly 2×PACK words popped, then `Read_enable`=0 and the first beat is stable; releasing `pkt_ready` resumes with no lost or duplicated words.
- Flush partial: push 0xA5 only, then pulse `flush` → `pkt_data` = 0x00000000_000000A5, `pkt_mask`=2'b01; no pop while `flush_pend` is set.
- Empty edge: `empty` toggles every cycle → pops occur only in cycles with `empty`=0, and the word order is preserved.
- Reset mid-beat: assert `reset` after 1 of 2 words has been captured → after release, the first beat contains only post-reset words.
